video_stream_packer: RTL and testbench

Parametrised multi-channel pixel selector and packer for the display path. It takes `NUM_CH` synchronised pixel streams (RGB, gray, binary, eroded, dilated) and selects one of them. Source and format changes take effect only on frame boundaries. Each pixel is formatted as RGB555, single gray byte, or two gray bytes per word. The block drives a registered valid/ready write port toward the SDRAM frame-buffer FIFO. Overflow is detected and the rest of the frame is dropped, so the buffer never receives a misaligned frame.

---
 rtl/uvispace_video_pkg.sv | 16 +
 rtl/pixel_formatter.sv | 35 +++
 rtl/video_stream_packer.sv | 145 ++++++++++++++
 tb/tb_video_stream_packer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uvispace_video_pkg.sv
// rtl/uvispace_video_pkg.sv - shared display-path mode constants, FSM state type and frame geometry
package uvispace_video_pkg;

  localparam logic [1:0] MODE_RGB555  = 2'd0;
  localparam logic [1:0] MODE_GRAY8   = 2'd1;
  localparam logic [1:0] MODE_GRAY8X2 = 2'd2;

  localparam int VGA_FRAME_PIXELS = 640 * 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DROP   = 2'd2
  } packer_state_t;

endpackage

// File: rtl/pixel_formatter.sv
// rtl/pixel_formatter.sv - combinational pixel-to-word formatter (RGB555 / GRAY8 / GRAY8X2)
module pixel_formatter
  import uvispace_video_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  pixel,
  input  logic [1:0]       mode,
  input  logic [7:0]       hold,
  input  logic             flush,
  output logic [OUT_W-1:0] word
);

  localparam int C = IN_W / 3;

  logic [C-1:0] r;
  logic [C-1:0] g;
  logic [C-1:0] b;

  assign r = pixel[3*C-1 -: C];
  assign g = pixel[2*C-1 -: C];
  assign b = pixel[C-1 -: C];

  // Build the word; a flush is the unpaired even pixel at frame end, upper byte left zero
  always_comb begin
    word = '0;
    case (mode)
      MODE_RGB555:  word[14:0] = {r[C-1 -: 5], g[C-1 -: 5], b[C-1 -: 5]};
      MODE_GRAY8X2: word[15:0] = flush ? {8'h00, pixel[7:0]} : {pixel[7:0], hold};
      default:      word[7:0]  = pixel[7:0];
    endcase
  end

endmodule

// File: rtl/video_stream_packer.sv
// rtl/video_stream_packer.sv - frame-aligned channel selector/packer; VIDEO_STREAM_PACKER_STATS_EN adds frame/drop counters
module video_stream_packer
  import uvispace_video_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int IN_W         = 24,
  parameter int OUT_W        = 16,
  parameter int FRAME_PIXELS = VGA_FRAME_PIXELS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_restart,
  input  logic [NUM_CH*IN_W-1:0]     in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [$clog2(NUM_CH)-1:0]  sel_ch,
  input  logic [1:0]                 sel_mode,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic [1:0]                 active_mode,
  output logic                       frame_done,
  output logic                       overflow
`ifdef VIDEO_STREAM_PACKER_STATS_EN
  ,
  output logic [15:0]                frame_count,
  output logic [15:0]                drop_count
`endif
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FRAME_PIXELS);

  packer_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        hold;

  logic [CH_W-1:0]   sel_ch_n;
  logic [1:0]        sel_mode_n;
  logic [IN_W-1:0]   px;
  logic              px_valid;
  logic              last;
  logic              flush;
  logic              need_word;
  logic              can_load;
  logic              pix_event;
  logic              frame_end;
  logic              ovf_event;
  logic [OUT_W-1:0]  word;

  // Normalise the requested selection: clamp channel, fold mode 3 onto GRAY8
  always_comb begin
    sel_ch_n = sel_ch;
    if (int'(sel_ch) >= NUM_CH) sel_ch_n = CH_W'(NUM_CH - 1);
    sel_mode_n = (sel_mode == 2'd3) ? MODE_GRAY8 : sel_mode;
  end

  assign px        = in_data[active_ch*IN_W +: IN_W];
  assign px_valid  = in_valid[active_ch];
  assign last      = (cnt == CNT_W'(FRAME_PIXELS - 1));
  assign flush     = (active_mode == MODE_GRAY8X2) && !cnt[0] && last;
  assign need_word = (active_mode != MODE_GRAY8X2) || cnt[0] || last;
  assign can_load  = !out_valid || out_ready;
  assign pix_event = (state != ST_IDLE) && !frame_restart && px_valid;
  assign frame_end = pix_event && last;
  assign ovf_event = pix_event && (state == ST_STREAM) && need_word && !can_load;

  pixel_formatter #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_fmt (
    .pixel (px),
    .mode  (active_mode),
    .hold  (hold),
    .flush (flush),
    .word  (word)
  );

  // Main FSM: selection latching, pixel counting, packing and overflow/drop handling
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hold        <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      active_ch   <= '0;
      active_mode <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        active_ch   <= sel_ch_n;
        active_mode <= sel_mode_n;
        cnt         <= '0;
        state       <= ST_STREAM;
      end else if (frame_restart) begin
        cnt         <= '0;
        hold        <= '0;
        active_ch   <= sel_ch_n;
        active_mode <= sel_mode_n;
        out_valid   <= 1'b0;
        state       <= ST_STREAM;
      end else if (px_valid) begin
        if (active_mode == MODE_GRAY8X2 && !cnt[0]) hold <= px[7:0];
        if (state == ST_STREAM && need_word) begin
          if (can_load) begin
            out_data  <= word;
            out_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
            state    <= ST_DROP;
          end
        end
        // Frame end resynchronises even out of DROP, so later assignments win
        if (last) begin
          cnt         <= '0;
          frame_done  <= 1'b1;
          active_ch   <= sel_ch_n;
          active_mode <= sel_mode_n;
          state       <= ST_STREAM;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef VIDEO_STREAM_PACKER_STATS_EN
  // Saturating frame and dropped-frame counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (frame_end && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if (ovf_event && drop_count != 16'hFFFF)  drop_count  <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_stream_packer.sv
// tb/tb_video_stream_packer.sv - directed self-checking bench for video_stream_packer
module tb_video_stream_packer;
  import uvispace_video_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_restart;
  logic [95:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel_ch;
  logic [1:0]  sel_mode;
  logic        out_ready;

  logic [15:0] o8_data, o5_data;
  logic        o8_valid, o5_valid;
  logic [1:0]  o8_ch, o5_ch, o8_mode, o5_mode;
  logic        o8_done, o5_done, o8_ovf, o5_ovf;
`ifdef VIDEO_STREAM_PACKER_STATS_EN
  logic [15:0] o8_fcnt, o8_dcnt, o5_fcnt, o5_dcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  video_stream_packer #(.NUM_CH(4), .IN_W(24), .OUT_W(16), .FRAME_PIXELS(8)) dut8 (
    .clk(clk), .reset(reset), .frame_restart(frame_restart),
    .in_data(in_data), .in_valid(in_valid), .sel_ch(sel_ch), .sel_mode(sel_mode),
    .out_data(o8_data), .out_valid(o8_valid), .out_ready(out_ready),
    .active_ch(o8_ch), .active_mode(o8_mode), .frame_done(o8_done), .overflow(o8_ovf)
`ifdef VIDEO_STREAM_PACKER_STATS_EN
    , .frame_count(o8_fcnt), .drop_count(o8_dcnt)
`endif
  );

  video_stream_packer #(.NUM_CH(4), .IN_W(24), .OUT_W(16), .FRAME_PIXELS(5)) dut5 (
    .clk(clk), .reset(reset), .frame_restart(frame_restart),
    .in_data(in_data), .in_valid(in_valid), .sel_ch(sel_ch), .sel_mode(sel_mode),
    .out_data(o5_data), .out_valid(o5_valid), .out_ready(out_ready),
    .active_ch(o5_ch), .active_mode(o5_mode), .frame_done(o5_done), .overflow(o5_ovf)
`ifdef VIDEO_STREAM_PACKER_STATS_EN
    , .frame_count(o5_fcnt), .drop_count(o5_dcnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gray_px(input logic [7:0] b);
    in_valid = 4'b0100;
    in_data  = {24'h0, 16'h0, b, 48'h0};
    tick();
  endtask

  initial begin
    reset = 1'b1; frame_restart = 1'b0; in_data = '0; in_valid = '0;
    sel_ch = 2'd2; sel_mode = 2'd2; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(o8_valid), 32'd0);
    check("rst_data",  32'(o8_data),  32'd0);
    check("rst_ch",    32'(o8_ch),    32'd0);
    check("rst_mode",  32'(o8_mode),  32'd0);
    check("rst_done",  32'(o8_done),  32'd0);
    check("rst_ovf",   32'(o8_ovf),   32'd0);

    reset = 1'b0;
    tick();
    check("idle_latch_ch",   32'(o8_ch),   32'd2);
    check("idle_latch_mode", 32'(o8_mode), 32'd2);

    // GRAY8X2 on channel 2: pairs 11/22, 33/44, then 55 ends the 5-pixel frame
    gray_px(8'h11);
    check("x2_even_held", 32'(o8_valid), 32'd0);
    gray_px(8'h22);
    check("x2_pair_valid", 32'(o8_valid), 32'd1);
    check("x2_pair_data",  32'(o8_data),  32'h2211);
    check("x2_pair_data5", 32'(o5_data),  32'h2211);
    gray_px(8'h33);
    gray_px(8'h44);
    check("x2_pair2_data", 32'(o8_data), 32'h4433);
    gray_px(8'h55);
    check("x2_flush_data",  32'(o5_data),  32'h0055);
    check("x2_flush_valid", 32'(o5_valid), 32'd1);
    check("x2_flush_done",  32'(o5_done),  32'd1);
    check("x2_no_done8",    32'(o8_done),  32'd0);
    sel_ch = 2'd0; sel_mode = 2'd0;
    gray_px(8'h66);
    gray_px(8'h77);
    gray_px(8'h88);
    check("x2_last_pair", 32'(o8_data), 32'h8877);
    check("x2_frame_done", 32'(o8_done), 32'd1);
    check("relatch_ch",   32'(o8_ch),   32'd0);
    check("relatch_mode", 32'(o8_mode), 32'd0);

    // RGB555 on ch0 with ch1 also valid; selection change mid-frame waits for frame end
    in_data  = {24'h0, 24'h0, 24'h00005A, 24'hF80CFF};
    in_valid = 4'b0011;
    tick();
    check("rgb_valid", 32'(o8_valid), 32'd1);
    check("rgb_data",  32'(o8_data),  32'h7C3F);
    in_valid = 4'b0010;
    tick();
    check("unsel_ignored", 32'(o8_valid), 32'd0);
    in_valid = 4'b0011;
    tick();
    tick();
    sel_ch = 2'd1; sel_mode = 2'd1;
    for (int i = 3; i < 8; i++) begin
      tick();
      check("switch_old_data", 32'(o8_data), 32'h7C3F);
      check("switch_done_edge", 32'(o8_done), (i == 7) ? 32'd1 : 32'd0);
    end
    check("switch_new_ch",   32'(o8_ch),   32'd1);
    check("switch_new_mode", 32'(o8_mode), 32'd1);

    // Drain, then overflow on the second pixel with the FIFO full
    in_valid = 4'b0000;
    tick();
    out_ready = 1'b0;
    in_valid = 4'b0011;
    tick();
    check("new_ch_data", 32'(o8_data), 32'h005A);
    check("pre_ovf",     32'(o8_ovf),  32'd0);
    tick();
    check("ovf_pulse",  32'(o8_ovf),   32'd1);
    check("ovf_hold",   32'(o8_data),  32'h005A);
    check("ovf_valid",  32'(o8_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      check("drop_quiet", 32'(o8_valid), 32'd0);
      check("drop_done",  32'(o8_done), (i == 7) ? 32'd1 : 32'd0);
      if (i == 2) check("ovf_one_cycle", 32'(o8_ovf), 32'd0);
    end
    tick();
    check("resync_valid", 32'(o8_valid), 32'd1);
    check("resync_data",  32'(o8_data),  32'h005A);
`ifdef VIDEO_STREAM_PACKER_STATS_EN
    check("stat_frames", 32'(o8_fcnt), 32'd3);
    check("stat_drops",  32'(o8_dcnt), 32'd1);
`endif

    // frame_restart at pixel 4 with a concurrent pixel
    repeat (3) tick();
    check("pre_restart_valid", 32'(o8_valid), 32'd1);
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;
    check("restart_valid", 32'(o8_valid), 32'd0);
    check("restart_done",  32'(o8_done),  32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("restart_count", 32'(o8_done), (i == 7) ? 32'd1 : 32'd0);
    end

    in_valid = 4'b0000;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
